brq_dccm_arbiter: RTL and testbench

- Two-requester arbiter sharing the single DCCM port between the Buraq core data port (core) and an external master (ext), e.g. a debug or program-loader engine.
- Sits between the core/ext masters and the DCCM instance in the top level.
- Round-robin grant, one-cycle pipelined read responses, full back-to-back throughput.

---
 rtl/brq_arb_pkg.sv | 19 +
 rtl/brq_rr_arb2.sv | 32 +++
 rtl/brq_dccm_arbiter.sv | 126 ++++++++++++
 tb/tb_brq_dccm_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_arb_pkg.sv
// Shared types for the DCCM arbiter: requester port ids and the memory request bundle.
package brq_arb_pkg;

  localparam int DataWidth = 32;
  localparam int AddrWidth = 15;

  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_EXT  = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [2:0]           byte_en;
  } mem_req_t;

endpackage

// File: rtl/brq_rr_arb2.sv
// Two-way round-robin arbiter; last_gnt flips priority on every grant, reset favours core.
module brq_rr_arb2
  import brq_arb_pkg::*;
(
  input  logic       brq_clk,
  input  logic       brq_rst,
  input  logic [1:0] req_vld,
  output logic [1:0] gnt
);

  arb_port_e last_gnt;

  // Grants are suppressed while reset is held so nothing reaches the DCCM.
  always_comb begin
    gnt = '0;
    if (!brq_rst) begin
      unique case (req_vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == ARB_EXT) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst)     last_gnt <= ARB_EXT;
    else if (gnt[0]) last_gnt <= ARB_CORE;
    else if (gnt[1]) last_gnt <= ARB_EXT;
  end

endmodule

// File: rtl/brq_dccm_arbiter.sv
// Shares the single DCCM port between core and ext masters with 1-cycle read responses.
// Optional stall counters are built when BRQ_DCCM_ARB_PERF_EN is defined.
module brq_dccm_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,

  input  logic                 core_req_valid,
  output logic                 core_req_ready,
  input  logic                 core_req_we,
  input  logic [AddrWidth-1:0] core_req_addr,
  input  logic [DataWidth-1:0] core_req_wdata,
  input  logic [2:0]           core_req_byte_en,
  output logic                 core_rsp_valid,
  output logic [DataWidth-1:0] core_rsp_rdata,

  input  logic                 ext_req_valid,
  output logic                 ext_req_ready,
  input  logic                 ext_req_we,
  input  logic [AddrWidth-1:0] ext_req_addr,
  input  logic [DataWidth-1:0] ext_req_wdata,
  input  logic [2:0]           ext_req_byte_en,
  output logic                 ext_rsp_valid,
  output logic [DataWidth-1:0] ext_rsp_rdata,

  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [2:0]           mem_byte_en,
  output logic [AddrWidth-1:0] mem_address,
  output logic [DataWidth-1:0] mem_data_in,
  input  logic [DataWidth-1:0] mem_data_out
`ifdef BRQ_DCCM_ARB_PERF_EN
  ,
  output logic [31:0]          core_stall_cnt,
  output logic [31:0]          ext_stall_cnt
`endif
);

  import brq_arb_pkg::*;

  // Index 0 is core, index 1 is ext throughout.
  logic     [1:0] req_vld;
  logic     [1:0] gnt;
  logic     [1:0] rsp_vld;
  mem_req_t [1:0] req;
  mem_req_t       sel;
  logic           granted;

  assign req_vld = {ext_req_valid, core_req_valid};

  assign req[0] = '{we: core_req_we, addr: core_req_addr,
                    wdata: core_req_wdata, byte_en: core_req_byte_en};
  assign req[1] = '{we: ext_req_we, addr: ext_req_addr,
                    wdata: ext_req_wdata, byte_en: ext_req_byte_en};

  brq_rr_arb2 u_arb (
    .brq_clk (brq_clk),
    .brq_rst (brq_rst),
    .req_vld (req_vld),
    .gnt     (gnt)
  );

  assign core_req_ready = gnt[0];
  assign ext_req_ready  = gnt[1];

  // sel stays all-zero without a grant, which zeroes every mem_* output.
  always_comb begin
    sel = '0;
    for (int p = 0; p < 2; p++) begin
      if (gnt[p]) sel = req[p];
    end
  end

  assign granted      = |gnt;
  assign mem_read_en  = granted & ~sel.we;
  assign mem_write_en = granted &  sel.we;
  assign mem_byte_en  = sel.byte_en;
  assign mem_address  = sel.addr;
  assign mem_data_in  = sel.wdata;

  // vld_pipe[0] is an accepted read this cycle; vld_pipe[1] is its returning data.
  logic [1:0] vld_pipe;
  arb_port_e  rsp_owner;

  assign vld_pipe[0] = mem_read_en;

  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      vld_pipe[1] <= 1'b0;
      rsp_owner   <= ARB_CORE;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) rsp_owner <= gnt[1] ? ARB_EXT : ARB_CORE;
    end
  end

  // Reset gates the response combinationally so a pending read is dropped at once.
  for (genvar p = 0; p < 2; p++) begin : g_rsp
    assign rsp_vld[p] = vld_pipe[1] & ~brq_rst &
                        (rsp_owner == ((p == 0) ? ARB_CORE : ARB_EXT));
  end

  assign core_rsp_valid = rsp_vld[0];
  assign ext_rsp_valid  = rsp_vld[1];
  assign core_rsp_rdata = mem_data_out;
  assign ext_rsp_rdata  = mem_data_out;

`ifdef BRQ_DCCM_ARB_PERF_EN
  logic [1:0][31:0] stall_cnt;

  for (genvar p = 0; p < 2; p++) begin : g_stall
    logic [31:0] cnt;
    always_ff @(posedge brq_clk) begin
      if (brq_rst)                               cnt <= '0;
      else if (req_vld[p] && !gnt[p] && cnt != '1) cnt <= cnt + 32'd1;
    end
    assign stall_cnt[p] = cnt;
  end

  assign core_stall_cnt = stall_cnt[0];
  assign ext_stall_cnt  = stall_cnt[1];
`endif

endmodule

// File: tb/tb_brq_dccm_arbiter.sv
// Randomised bench for brq_dccm_arbiter against a transaction-level model and DCCM stub.
module tb_brq_dccm_arbiter;

  logic        brq_clk = 1'b0;
  logic        brq_rst = 1'b1;
  logic        core_req_valid = 1'b0, core_req_ready, core_req_we = 1'b0;
  logic [14:0] core_req_addr = '0;
  logic [31:0] core_req_wdata = '0;
  logic [2:0]  core_req_byte_en = '0;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_rdata;
  logic        ext_req_valid = 1'b0, ext_req_ready, ext_req_we = 1'b0;
  logic [14:0] ext_req_addr = '0;
  logic [31:0] ext_req_wdata = '0;
  logic [2:0]  ext_req_byte_en = '0;
  logic        ext_rsp_valid;
  logic [31:0] ext_rsp_rdata;
  logic        mem_read_en, mem_write_en;
  logic [2:0]  mem_byte_en;
  logic [14:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
`ifdef BRQ_DCCM_ARB_PERF_EN
  logic [31:0] core_stall_cnt, ext_stall_cnt;
`endif

  always #5 brq_clk = ~brq_clk;

  brq_dccm_arbiter dut (
    .brq_clk(brq_clk), .brq_rst(brq_rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_byte_en(core_req_byte_en),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
    .ext_req_we(ext_req_we), .ext_req_addr(ext_req_addr),
    .ext_req_wdata(ext_req_wdata), .ext_req_byte_en(ext_req_byte_en),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_rdata(ext_rsp_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_byte_en(mem_byte_en), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
`ifdef BRQ_DCCM_ARB_PERF_EN
    , .core_stall_cnt(core_stall_cnt), .ext_stall_cnt(ext_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_val(input logic [14:0] a);
    return 32'h5A00_0000 ^ ({17'd0, a} * 32'h0000_9E37);
  endfunction

  // DCCM stub: whole-word storage, read data one cycle after read enable.
  logic [31:0] dccm [int];
  always @(posedge brq_clk) begin
    if (mem_write_en) dccm[int'(mem_address)] = mem_data_in;
    if (mem_read_en)
      mem_data_out <= dccm.exists(int'(mem_address)) ? dccm[int'(mem_address)]
                                                     : init_val(mem_address);
  end

  typedef struct {
    bit          v;
    bit          we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [2:0]  be;
  } tb_req_t;

  tb_req_t     pend [2];
  logic [31:0] ref_mem [int];
  int          m_last;
  bit          m_rsp_vld;
  int          m_rsp_own;
  logic [31:0] m_rsp_data;
  longint      m_stall [2];
  bit          known;
  bit          rst_in, rand_en;
  int          n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  task automatic set_req(input int p, input bit we, input logic [14:0] a,
                         input logic [31:0] d, input logic [2:0] be);
    pend[p].v = 1; pend[p].we = we; pend[p].addr = a; pend[p].wdata = d; pend[p].be = be;
  endtask

  // One clock: drive, check against the model at negedge, then advance the model.
  task automatic cycle();
    int win;
    tb_req_t w;
    @(posedge brq_clk); #1;
    if (rand_en) begin
      rst_in = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 99) < 70)
          set_req(p, $urandom_range(0, 1), 15'(($urandom_range(0, 3) << 13) | $urandom_range(0, 7)),
                  $urandom, 3'($urandom_range(0, 7)));
    end
    brq_rst          = rst_in;
    core_req_valid   = pend[0].v;   core_req_we   = pend[0].we;
    core_req_addr    = pend[0].addr; core_req_wdata = pend[0].wdata;
    core_req_byte_en = pend[0].be;
    ext_req_valid    = pend[1].v;   ext_req_we    = pend[1].we;
    ext_req_addr     = pend[1].addr; ext_req_wdata = pend[1].wdata;
    ext_req_byte_en  = pend[1].be;
    @(negedge brq_clk);

    win = -1;
    if (!rst_in) begin
      if (pend[0].v && pend[1].v) win = 1 - m_last;
      else if (pend[0].v)         win = 0;
      else if (pend[1].v)         win = 1;
    end
    w = (win >= 0) ? pend[win] : '{0, 0, 15'd0, 32'd0, 3'd0};

    chk("core_ready", core_req_ready, win == 0);
    chk("ext_ready", ext_req_ready, win == 1);
    chk("mem_read_en", mem_read_en, win >= 0 && !w.we);
    chk("mem_write_en", mem_write_en, win >= 0 && w.we);
    chk("mem_address", mem_address, w.addr);
    chk("mem_data_in", mem_data_in, w.wdata);
    chk("mem_byte_en", mem_byte_en, w.be);
    chk("core_rsp_valid", core_rsp_valid, !rst_in && m_rsp_vld && m_rsp_own == 0);
    chk("ext_rsp_valid", ext_rsp_valid, !rst_in && m_rsp_vld && m_rsp_own == 1);
    if (!rst_in && m_rsp_vld) begin
      chk("core_rsp_rdata", core_rsp_rdata, m_rsp_data);
      chk("ext_rsp_rdata", ext_rsp_rdata, m_rsp_data);
    end
`ifdef BRQ_DCCM_ARB_PERF_EN
    if (known) begin
      chk("core_stall_cnt", core_stall_cnt, m_stall[0]);
      chk("ext_stall_cnt", ext_stall_cnt, m_stall[1]);
    end
`endif

    for (int p = 0; p < 2; p++)
      if (rst_in) m_stall[p] = 0;
      else if (pend[p].v && win != p && m_stall[p] < 64'hFFFF_FFFF) m_stall[p]++;
    m_rsp_vld = 0;
    if (rst_in) begin
      m_last = 1;
      known  = 1;
    end else if (win >= 0) begin
      if (w.we) ref_mem[int'(w.addr)] = w.wdata;
      else begin
        m_rsp_vld  = 1;
        m_rsp_own  = win;
        m_rsp_data = ref_rd(w.addr);
      end
      m_last = win;
      pend[win].v = 0;
    end
  endtask

  initial begin
    pend[0] = '{0, 0, 15'd0, 32'd0, 3'd0};
    pend[1] = '{0, 0, 15'd0, 32'd0, 3'd0};
    m_last = 1; m_rsp_vld = 0; m_rsp_own = 0; m_rsp_data = '0;
    m_stall[0] = 0; m_stall[1] = 0; known = 0; rand_en = 0;
    dccm[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;

    // Reset state
    rst_in = 1;
    cycle(); cycle();
    chk("rst_core_ready", core_req_ready, 1'b0);
    rst_in = 0;

    // Core read alone
    set_req(0, 0, 15'h0010, 32'h0, 3'b111);
    cycle();
    chk("tp1_ready", core_req_ready, 1'b1);
    chk("tp1_rd_en", mem_read_en, 1'b1);
    cycle();
    chk("tp1_rsp_valid", core_rsp_valid, 1'b1);
    chk("tp1_rdata", core_rsp_rdata, 32'hDEAD_BEEF);
    chk("tp1_ext_valid", ext_rsp_valid, 1'b0);

    // Contention after reset: core first, ext next, then alternation
    rst_in = 1; cycle(); rst_in = 0;
    set_req(0, 1, 15'h0004, 32'h1111_1111, 3'b111);
    set_req(1, 0, 15'h0008, 32'h0, 3'b111);
    cycle();
    chk("tp2_core_first", core_req_ready, 1'b1);
    cycle();
    chk("tp2_ext_second", ext_req_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v) set_req(p, $urandom_range(0, 1), 15'($urandom_range(0, 31)), $urandom, 3'd7);
      cycle();
    end
    pend[0].v = 0; pend[1].v = 0;
    cycle(); cycle();

    // Back-to-back ext reads
    for (int i = 0; i < 3; i++) begin
      set_req(1, 0, 15'(i), 32'h0, 3'b111);
      cycle();
      if (i > 0) chk("tp3_b2b_valid", ext_rsp_valid, 1'b1);
    end
    cycle();
    chk("tp3_last_valid", ext_rsp_valid, 1'b1);
    chk("tp3_last_data", ext_rsp_rdata, init_val(15'd2));

    // Write then read same address
    set_req(0, 1, 15'h0020, 32'hCAFE_F00D, 3'b010);
    cycle();
    set_req(0, 0, 15'h0020, 32'h0, 3'b010);
    cycle();
    cycle();
    chk("tp4_raw_data", core_rsp_rdata, 32'hCAFE_F00D);

    // Reset mid-read
    set_req(0, 0, 15'h0030, 32'h0, 3'b111);
    cycle();
    rst_in = 1;
    cycle();
    chk("tp5_no_rsp", core_rsp_valid, 1'b0);
    chk("tp5_rd_en", mem_read_en, 1'b0);
    rst_in = 0;
    cycle();
    chk("tp5_no_rsp_late", core_rsp_valid, 1'b0);
    set_req(0, 0, 15'h0040, 32'h0, 3'b111);
    set_req(1, 0, 15'h0041, 32'h0, 3'b111);
    cycle();
    chk("tp5_core_wins", core_req_ready, 1'b1);
    cycle();

    // Stall counting: ext held valid while core keeps competing
    for (int i = 0; i < 5; i++) begin
      if (!pend[0].v) set_req(0, 0, 15'(i), 32'h0, 3'b111);
      if (!pend[1].v && i == 0) set_req(1, 1, 15'h7FFF, 32'h1234_5678, 3'b001);
      cycle();
    end
    pend[0].v = 0; pend[1].v = 0;
    cycle(); cycle();

    // Randomised traffic
    rand_en = 1;
    for (int i = 0; i < 3000; i++) cycle();
    rand_en = 0; rst_in = 0;
    pend[0].v = 0; pend[1].v = 0;
    cycle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
